data_mem_lsu: RTL and testbench

//  Load/store unit and word-addressed data memory for the sort CPU, downstream of the execute stage.

---
 rtl/data_mem_lsu.sv | 129 ++++++++++++
 tb/tb_data_mem_lsu.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// Load/store unit with a word-addressed data memory of fixed access latency.
// Handles one request at a time and holds the response until it is consumed.
//
// state | meaning
// IDLE  | ready for a request; the next valid request is latched
// WAIT  | latency countdown; the access is performed when the counter reaches 0
// RESP  | response held on the outputs until resp_ready
module data_mem_lsu #(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [3:0]    cnt;
    logic          lat_we;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_be;
    logic          accept;
    logic          access;
    logic          addr_err;
    logic [AW-1:0] word_idx;

    logic [31:0] memory_data [0:DEPTH-1];

    assign accept   = (state == IDLE) && req_valid;
    assign access   = (state == WAIT) && (cnt == 4'd0);
    assign addr_err = (lat_addr[1:0] != 2'b00) || (lat_addr[31:AW+2] != '0);
    assign word_idx = lat_addr[AW+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, latency counter and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 4'd0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_be     <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
                cnt       <= 4'(LATENCY - 1);
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                resp_err   <= addr_err;
                resp_rdata <= (!lat_we && !addr_err) ? memory_data[word_idx] : 32'd0;
            end
        end
    end

    // Memory contents survive reset; an aborted request never reaches access.
    always_ff @(posedge clk) begin
        if (access && lat_we && !addr_err) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) begin
                    memory_data[word_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: three instances (LATENCY 2, 1, 5) checked every cycle
// against a transaction-level model of memory contents and response timing.
module tb_data_mem_lsu;

    localparam int DEPTH   = 32;
    localparam int LATS[3] = '{2, 1, 5};

    logic        clk;
    logic        rst;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_we     [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic [3:0]  req_be     [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];
    logic        busy       [3];

    int nerr = 0;
    int nchk = 0;
    int cyc  = 0;

    // Model: mirrored memory plus the one outstanding transaction per instance.
    logic [31:0] mmem      [3][DEPTH];
    bit          pend      [3];
    int          acc       [3];
    int          due       [3];
    logic [31:0] exp_rdata [3];
    logic        exp_err   [3];

    data_mem_lsu #(.DEPTH(32), .AW(5), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0]), .busy(busy[0]));

    data_mem_lsu #(.DEPTH(32), .AW(5), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1]), .busy(busy[1]));

    data_mem_lsu #(.DEPTH(32), .AW(5), .LATENCY(5)) u_l5 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]),
        .resp_err(resp_err[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] mem_peek(int k, int i);
        case (k)
            0:       return u_l2.memory_data[i];
            1:       return u_l1.memory_data[i];
            default: return u_l5.memory_data[i];
        endcase
    endfunction

    task automatic mem_poke(int k, int i, logic [31:0] v);
        case (k)
            0:       u_l2.memory_data[i] = v;
            1:       u_l1.memory_data[i] = v;
            default: u_l5.memory_data[i] = v;
        endcase
        mmem[k][i] = v;
    endtask

    task automatic mem_check_all(int k);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("k%0d mem[%0d]", k, i), mem_peek(k, i), mmem[k][i]);
        end
    endtask

    // Architectural effect of one request, straight from the address/byte-enable rules.
    function automatic void model_req(int k, bit we, logic [31:0] a, logic [31:0] wd,
                                      logic [3:0] be, output logic [31:0] rd, output logic er);
        int idx;
        er = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
        rd = 32'd0;
        if (!er) begin
            idx = int'(a >> 2);
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mmem[k][idx][8*i +: 8] = wd[8*i +: 8];
                end
            end else begin
                rd = mmem[k][idx];
            end
        end
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
        if (r == 1) return (32'($urandom_range(1, 1000)) << 7) | 32'($urandom_range(0, 31) * 4);
        return 32'($urandom_range(0, DEPTH - 1) * 4);
    endfunction

    // One compare process: every cycle, every instance against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                chk($sformatf("k%0d rst req_ready", k), 32'(req_ready[k]), 32'd1);
                chk($sformatf("k%0d rst resp_valid", k), 32'(resp_valid[k]), 32'd0);
                chk($sformatf("k%0d rst busy", k), 32'(busy[k]), 32'd0);
                chk($sformatf("k%0d rst rdata", k), resp_rdata[k], 32'd0);
                chk($sformatf("k%0d rst err", k), 32'(resp_err[k]), 32'd0);
            end else if (!pend[k]) begin
                chk($sformatf("k%0d idle req_ready", k), 32'(req_ready[k]), 32'd1);
                chk($sformatf("k%0d idle resp_valid", k), 32'(resp_valid[k]), 32'd0);
                chk($sformatf("k%0d idle busy", k), 32'(busy[k]), 32'd0);
            end else begin
                chk($sformatf("k%0d pend req_ready", k), 32'(req_ready[k]), 32'd0);
                chk($sformatf("k%0d pend busy", k), 32'(busy[k]), 32'd1);
                chk($sformatf("k%0d resp_valid", k), 32'(resp_valid[k]), 32'(cyc >= due[k]));
                if (cyc >= due[k]) begin
                    chk($sformatf("k%0d rdata", k), resp_rdata[k], exp_rdata[k]);
                    chk($sformatf("k%0d err", k), 32'(resp_err[k]), 32'(exp_err[k]));
                end
            end
        end
    end

    task automatic issue(int k, bit we, logic [31:0] a, logic [31:0] wd, logic [3:0] be);
        req_we[k]    = we;
        req_addr[k]  = a;
        req_wdata[k] = wd;
        req_be[k]    = be;
        req_valid[k] = 1'b1;
        @(posedge clk); #1;
        model_req(k, we, a, wd, be, exp_rdata[k], exp_err[k]);
        pend[k] = 1'b1;
        acc[k]  = cyc;
        due[k]  = cyc + LATS[k];
        req_valid[k] = 1'b0;
        req_we[k]    = 1'($urandom);
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        req_be[k]    = 4'($urandom);
    endtask

    task automatic wait_valid(int k);
        int n;
        n = 0;
        while (resp_valid[k] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("k%0d accept-to-valid gap", k), 32'(cyc - acc[k]), 32'(LATS[k]));
    endtask

    task automatic finish_resp(int k, int hold, bit overlap,
                               output logic [31:0] rd, output logic er);
        wait_valid(k);
        rd = resp_rdata[k];
        er = resp_err[k];
        repeat (hold) begin
            @(posedge clk); #1;
            chk($sformatf("k%0d held rdata", k), resp_rdata[k], rd);
        end
        resp_ready[k] = 1'b1;
        // A request offered during RESP must wait for IDLE.
        if (overlap) begin
            req_valid[k] = 1'b1;
            req_we[k]    = 1'($urandom);
            req_addr[k]  = rand_addr();
            req_wdata[k] = $urandom;
            req_be[k]    = 4'($urandom);
        end
        @(posedge clk); #1;
        resp_ready[k] = 1'b0;
        pend[k] = 1'b0;
    endtask

    task automatic txn(int k, bit we, logic [31:0] a, logic [31:0] wd, logic [3:0] be,
                       int hold, bit overlap, output logic [31:0] rd, output logic er);
        issue(k, we, a, wd, be);
        finish_resp(k, hold, overlap, rd, er);
        if (a < 32'(DEPTH * 4)) begin
            chk($sformatf("k%0d mem after txn", k), mem_peek(k, int'(a >> 2)), mmem[k][int'(a >> 2)]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] sweep_vals [5];
        sweep_vals = '{32'd76, 32'd4, 32'd35, 32'd2, 32'd18};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pend[k]       = 1'b0;
            req_valid[k]  = 1'b0;
            resp_ready[k] = 1'b0;
            req_we[k]     = 1'b0;
            req_addr[k]   = 32'd0;
            req_wdata[k]  = 32'd0;
            req_be[k]     = 4'd0;
            for (int i = 0; i < DEPTH; i++) mem_poke(k, i, $urandom);
        end
        @(negedge clk); #1;
        chk("reset req_ready", 32'(req_ready[0]), 32'd1);
        chk("reset rdata", resp_rdata[0], 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        mem_poke(0, 2, 32'd35);
        txn(0, 1'b0, 32'h08, 32'h0, 4'hF, 0, 1'b0, rd, er);
        chk("load word2 rdata", rd, 32'd35);
        chk("load word2 err", 32'(er), 32'd0);

        mem_poke(0, 4, 32'd18);
        txn(0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 0, 1'b0, rd, er);
        chk("store rdata", rd, 32'd0);
        chk("store word4", mem_peek(0, 4), 32'h00BB00DD);

        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b0, rd, er);
        chk("backpressure load rdata", rd, 32'h00BB00DD);

        txn(0, 1'b1, 32'h10, 32'h12345678, 4'b0000, 1, 1'b0, rd, er);
        chk("be0 store word4", mem_peek(0, 4), 32'h00BB00DD);

        txn(0, 1'b0, 32'h06, 32'h0, 4'hF, 0, 1'b0, rd, er);
        chk("misaligned err", 32'(er), 32'd1);
        chk("misaligned rdata", rd, 32'd0);
        txn(0, 1'b1, 32'h80, 32'hFFFFFFFF, 4'hF, 0, 1'b0, rd, er);
        chk("range err", 32'(er), 32'd1);
        chk("range rdata", rd, 32'd0);
        mem_check_all(0);

        for (int t = 0; t < 60; t++) begin
            txn(0, 1'($urandom), rand_addr(), $urandom, 4'($urandom),
                $urandom_range(0, 3), (t < 59) ? 1'($urandom) : 1'b0, rd, er);
        end
        mem_check_all(0);

        // Reset during WAIT discards the store.
        mem_poke(0, 1, 32'd4);
        issue(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF);
        #1 rst = 1'b1;
        pend[0] = 1'b0;
        mmem[0][1] = 32'd4;
        #1;
        chk("rst mid-wait req_ready", 32'(req_ready[0]), 32'd1);
        chk("rst mid-wait busy", 32'(busy[0]), 32'd0);
        chk("rst mid-wait resp_valid", 32'(resp_valid[0]), 32'd0);
        @(negedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("rst mid-wait word1", mem_peek(0, 1), 32'd4);

        // Reset during RESP keeps the completed store.
        issue(0, 1'b1, 32'h0C, 32'hCAFEF00D, 4'hF);
        wait_valid(0);
        #1 rst = 1'b1;
        pend[0] = 1'b0;
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst in resp word3", mem_peek(0, 3), 32'hCAFEF00D);

        for (int k = 1; k < 3; k++) begin
            for (int i = 0; i < 5; i++) mem_poke(k, i, sweep_vals[i]);
            for (int i = 0; i < 5; i++) begin
                txn(k, 1'b0, 32'(i * 4), 32'h0, 4'h0, 0, (i < 4), rd, er);
                chk($sformatf("k%0d sweep word%0d", k, i), rd, sweep_vals[i]);
            end
            for (int t = 0; t < 15; t++) begin
                txn(k, 1'($urandom), rand_addr(), $urandom, 4'($urandom),
                    $urandom_range(0, 2), (t < 14) ? 1'($urandom) : 1'b0, rd, er);
            end
        end
        for (int k = 0; k < 3; k++) mem_check_all(k);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
